// File: rtl/delay_sensor_sweep_ctrl.sv
// Delay-sensor sweep sequencer: steps through the taps, lets each one settle,
// counts high sensor samples over a fixed window, and reports per-tap results.
module delay_sensor_sweep_ctrl #(
   parameter int N_TAPS     = 4,
   parameter int TAP_W      = 2,
   parameter int SETTLE_CYC = 4,
   parameter int WIN_LOG2   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                continuous,
   input  logic                abort,
   input  logic                sense_in,
   output logic                sensor_en,
   output logic [TAP_W-1:0]    tap_sel,
   output logic                busy,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [TAP_W-1:0]    res_tap,
   output logic [WIN_LOG2:0]   res_count,
   output logic                sweep_done
);

   localparam int CNT_W = WIN_LOG2 + 1;
   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int CYC_W = (SET_W > CNT_W) ? SET_W : CNT_W;

   localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE_CYC - 1);
   localparam logic [CYC_W-1:0] WIN_LAST = CYC_W'((1 << WIN_LOG2) - 1);
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      REPORT  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [TAP_W-1:0]   tap_sel_q, tap_sel_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               res_valid_q, res_valid_d;
   logic [TAP_W-1:0]   res_tap_q, res_tap_d;
   logic [CNT_W-1:0]   res_count_q, res_count_d;
   logic               sweep_done_q, sweep_done_d;
   logic               busy_q, busy_d;
   logic               sensor_en_q, sensor_en_d;
   logic               sync1_q, sync1_d;
   logic               sense_s_q, sense_s_d;

   // Next-state logic: synchronizer, sequencing FSM, window counter, result port
   always_comb begin
      state_d      = state_q;
      tap_sel_d    = tap_sel_q;
      cyc_d        = cyc_q;
      count_d      = count_q;
      res_valid_d  = res_valid_q;
      res_tap_d    = res_tap_q;
      res_count_d  = res_count_q;
      sweep_done_d = 1'b0;
      sync1_d      = sense_in;
      sense_s_d    = sync1_q;

      if (abort) begin
         state_d     = IDLE;
         tap_sel_d   = '0;
         cyc_d       = '0;
         res_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d   = SETTLE;
                  tap_sel_d = '0;
                  cyc_d     = '0;
               end
            end
            SETTLE: begin
               if (cyc_q == SET_LAST) begin
                  state_d = MEASURE;
                  cyc_d   = '0;
                  count_d = '0;
               end else begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
            end
            MEASURE: begin
               count_d = count_q + CNT_W'(sense_s_q);
               if (cyc_q == WIN_LAST) begin
                  state_d = REPORT;
               end else begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
            end
            REPORT: begin
               // First REPORT cycle latches the finished window into the port
               if (!res_valid_q) begin
                  res_valid_d = 1'b1;
                  res_tap_d   = tap_sel_q;
                  res_count_d = count_q;
               end else if (res_ready) begin
                  res_valid_d = 1'b0;
                  cyc_d       = '0;
                  if (tap_sel_q == TAP_LAST) begin
                     sweep_done_d = 1'b1;
                     tap_sel_d    = '0;
                     state_d      = continuous ? SETTLE : IDLE;
                  end else begin
                     tap_sel_d = tap_sel_q + TAP_W'(1);
                     state_d   = SETTLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d      = (state_d != IDLE);
      sensor_en_d = (state_d != IDLE);
   end

   // State and registered outputs, all cleared by asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tap_sel_q    <= '0;
         cyc_q        <= '0;
         count_q      <= '0;
         res_valid_q  <= 1'b0;
         res_tap_q    <= '0;
         res_count_q  <= '0;
         sweep_done_q <= 1'b0;
         busy_q       <= 1'b0;
         sensor_en_q  <= 1'b0;
         sync1_q      <= 1'b0;
         sense_s_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tap_sel_q    <= tap_sel_d;
         cyc_q        <= cyc_d;
         count_q      <= count_d;
         res_valid_q  <= res_valid_d;
         res_tap_q    <= res_tap_d;
         res_count_q  <= res_count_d;
         sweep_done_q <= sweep_done_d;
         busy_q       <= busy_d;
         sensor_en_q  <= sensor_en_d;
         sync1_q      <= sync1_d;
         sense_s_q    <= sense_s_d;
      end
   end

   assign sensor_en  = sensor_en_q;
   assign tap_sel    = tap_sel_q;
   assign busy       = busy_q;
   assign res_valid  = res_valid_q;
   assign res_tap    = res_tap_q;
   assign res_count  = res_count_q;
   assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_delay_sensor_sweep_ctrl.sv
// Bench for delay_sensor_sweep_ctrl: randomized sensor patterns checked
// against a per-cycle sample history and the documented window timing.
module tb_delay_sensor_sweep_ctrl;

   localparam int N_TAPS = 4;
   localparam int TAP_W  = 2;
   localparam int SETTLE = 4;
   localparam int WLOG   = 4;
   localparam int WIN    = 1 << WLOG;
   localparam int LAT    = SETTLE + WIN + 1;
   localparam int HMAX   = 8192;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             continuous;
   logic             abort;
   logic             sense_in;
   logic             sensor_en;
   logic [TAP_W-1:0] tap_sel;
   logic             busy;
   logic             res_valid;
   logic             res_ready;
   logic [TAP_W-1:0] res_tap;
   logic [WLOG:0]    res_count;
   logic             sweep_done;

   delay_sensor_sweep_ctrl #(
      .N_TAPS(N_TAPS), .TAP_W(TAP_W), .SETTLE_CYC(SETTLE), .WIN_LOG2(WLOG)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .abort(abort), .sense_in(sense_in), .sensor_en(sensor_en),
      .tap_sel(tap_sel), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_tap(res_tap), .res_count(res_count),
      .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   bit hist [HMAX];
   int tests_run = 0;
   int fails = 0;
   int mode = 0;
   int tcnt = 0;

   // Record the sense_in level seen at every rising edge
   always @(posedge clk) begin
      if (edge_n < HMAX) hist[edge_n] <= sense_in;
      edge_n <= edge_n + 1;
   end

   // Reference: high samples of sense_in that land in the window, given that
   // the window follows SETTLE cycles and sees input delayed by two flops
   function automatic int exp_count(input int e);
      int s = 0;
      for (int k = e + SETTLE - 1; k <= e + SETTLE + WIN - 2; k++)
         if (k >= 0 && k < HMAX) s += int'(hist[k]);
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      tcnt++;
      case (mode)
         0: sense_in = 1'b0;
         1: sense_in = 1'b1;
         2: sense_in = ~sense_in;
         3: if (tcnt % 2 == 0) sense_in = ~sense_in;
         default: sense_in = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_start(output int e);
      start = 1'b1;
      step();
      e = edge_n - 1;
      start = 1'b0;
   endtask

   task automatic get_result(input int e, output int lat, output int tap,
                             output int cnt, output int ex);
      int n = 0;
      while (!res_valid && n < 300) begin
         step();
         n++;
      end
      lat = res_valid ? (edge_n - 1 - e) : -1;
      tap = int'(res_tap);
      cnt = int'(res_count);
      ex  = exp_count(e);
   endtask

   task automatic handshake(input int d, output int h, output bit done,
                            output bit vld);
      if (d > 0) begin
         res_ready = 1'b0;
         repeat (d) step();
      end
      res_ready = 1'b1;
      step();
      h    = edge_n - 1;
      done = sweep_done;
      vld  = res_valid;
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      rst = 1'b1; start = 1'b1; continuous = 1'b0; abort = 1'b0;
      sense_in = 1'b1; res_ready = 1'b1;
      repeat (3) step();
      outs = {sensor_en, tap_sel, busy, res_valid, res_tap, res_count,
              sweep_done};
      tests_run++;
      if (outs !== 32'd0) begin
         fails++;
         $display("FAIL reset_outputs got=%h want=0", outs);
      end
      start = 1'b0;
      rst = 1'b0;
      step();
      tests_run++;
      if (busy !== 1'b0 || sensor_en !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle busy=%b en=%b want 0", busy, sensor_en);
      end
   endtask

   task automatic test_pattern(input int m, input string nm);
      int e, lat, tap, cnt, ex, h, cexp, d;
      bit done, vld;
      mode = m;
      cexp = (m == 0) ? 0 : (m == 1) ? WIN : (m <= 3) ? WIN / 2 : -1;
      res_ready = (m == 4) ? 1'b0 : 1'b1;
      repeat (3) step();
      do_start(e);
      for (int i = 0; i < N_TAPS; i++) begin
         get_result(e, lat, tap, cnt, ex);
         tests_run++;
         if (lat !== LAT || tap !== i || cnt !== ex) begin
            fails++;
            $display("FAIL %s tap%0d lat=%0d tap=%0d cnt=%0d want %0d/%0d/%0d",
                     nm, i, lat, tap, cnt, LAT, i, ex);
         end
         if (cexp >= 0) begin
            tests_run++;
            if (cnt !== cexp) begin
               fails++;
               $display("FAIL %s_const tap%0d cnt=%0d want %0d",
                        nm, i, cnt, cexp);
            end
         end
         d = (m == 4) ? $urandom_range(0, 5) : 0;
         handshake(d, h, done, vld);
         tests_run++;
         if (vld !== 1'b0 || done !== (i == N_TAPS - 1)) begin
            fails++;
            $display("FAIL %s hs%0d valid=%b done=%b want 0/%b",
                     nm, i, vld, done, i == N_TAPS - 1);
         end
         res_ready = (m == 4) ? 1'b0 : 1'b1;
         e = h;
      end
      step();
      tests_run++;
      if (busy !== 1'b0 || sweep_done !== 1'b0 || res_valid !== 1'b0) begin
         fails++;
         $display("FAIL %s end busy=%b done=%b valid=%b want 0",
                  nm, busy, sweep_done, res_valid);
      end
   endtask

   task automatic test_backpressure();
      int e, lat, tap, cnt, ex;
      mode = 4;
      res_ready = 1'b0;
      do_start(e);
      get_result(e, lat, tap, cnt, ex);
      tests_run++;
      if (lat !== LAT || tap !== 0 || cnt !== ex) begin
         fails++;
         $display("FAIL bp_first lat=%0d tap=%0d cnt=%0d want %0d/0/%0d",
                  lat, tap, cnt, LAT, ex);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         tests_run++;
         if (res_valid !== 1'b1 || int'(res_tap) !== 0 ||
             int'(res_count) !== ex || tap_sel !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold c%0d v=%b tap=%0d cnt=%0d sel=%0d want 1/0/%0d/0",
                     i, res_valid, res_tap, res_count, tap_sel, ex);
         end
      end
      res_ready = 1'b1;
      step();
      tests_run++;
      if (res_valid !== 1'b0 || int'(tap_sel) !== 1) begin
         fails++;
         $display("FAIL bp_release valid=%b sel=%0d want 0/1",
                  res_valid, tap_sel);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_abort();
      int e, lat, tap, cnt, ex, h;
      bit done, vld, seen_v, seen_d;
      mode = 1;
      res_ready = 1'b1;
      do_start(e);
      for (int i = 0; i < 2; i++) begin
         get_result(e, lat, tap, cnt, ex);
         handshake(0, h, done, vld);
         e = h;
      end
      repeat (SETTLE + 8) step();
      tests_run++;
      if (int'(tap_sel) !== 2 || busy !== 1'b1 || res_valid !== 1'b0) begin
         fails++;
         $display("FAIL abort_pre sel=%0d busy=%b v=%b want 2/1/0",
                  tap_sel, busy, res_valid);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || sensor_en !== 1'b0 || tap_sel !== '0 ||
          res_valid !== 1'b0 || sweep_done !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle busy=%b en=%b sel=%0d v=%b d=%b want 0",
                  busy, sensor_en, tap_sel, res_valid, sweep_done);
      end
      seen_v = 1'b0;
      seen_d = 1'b0;
      repeat (40) begin
         step();
         seen_v |= res_valid;
         seen_d |= sweep_done;
      end
      tests_run++;
      if (seen_v !== 1'b0 || seen_d !== 1'b0) begin
         fails++;
         $display("FAIL abort_quiet valid=%b done=%b want 0/0", seen_v, seen_d);
      end
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_vs_start busy=%b want 0", busy);
      end
      do_start(e);
      get_result(e, lat, tap, cnt, ex);
      tests_run++;
      if (lat !== LAT || tap !== 0 || cnt !== WIN) begin
         fails++;
         $display("FAIL abort_restart lat=%0d tap=%0d cnt=%0d want %0d/0/%0d",
                  lat, tap, cnt, LAT, WIN);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_continuous();
      int e, lat, tap, cnt, ex, h;
      bit done, vld;
      logic [31:0] outs;
      mode = 4;
      res_ready = 1'b1;
      continuous = 1'b1;
      do_start(e);
      for (int i = 0; i < 8; i++) begin
         get_result(e, lat, tap, cnt, ex);
         tests_run++;
         if (lat !== LAT || tap !== i % N_TAPS || cnt !== ex) begin
            fails++;
            $display("FAIL cont r%0d lat=%0d tap=%0d cnt=%0d want %0d/%0d/%0d",
                     i, lat, tap, cnt, LAT, i % N_TAPS, ex);
         end
         if (i == 5) continuous = 1'b0;
         handshake(0, h, done, vld);
         tests_run++;
         if (done !== (i % N_TAPS == N_TAPS - 1)) begin
            fails++;
            $display("FAIL cont_done r%0d done=%b want %b",
                     i, done, i % N_TAPS == N_TAPS - 1);
         end
         e = h;
      end
      step();
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL cont_end busy=%b want 0", busy);
      end
      do_start(e);
      step();
      step();
      tests_run++;
      if (busy !== 1'b1 || sensor_en !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre busy=%b en=%b want 1/1", busy, sensor_en);
      end
      #1 rst = 1'b1;
      #1;
      outs = {sensor_en, tap_sel, busy, res_valid, res_tap, res_count,
              sweep_done};
      tests_run++;
      if (outs !== 32'd0) begin
         fails++;
         $display("FAIL rst_async got=%h want=0", outs);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_pattern(1, "ones");
      test_pattern(0, "zeros");
      test_pattern(2, "toggle1");
      test_pattern(3, "toggle2");
      test_pattern(4, "random_a");
      test_pattern(4, "random_b");
      test_backpressure();
      test_abort();
      test_continuous();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
